id_issue_control: RTL

ID-stage issue controller for the 5-stage pipeline. It decodes the IF/ID instruction into the EX control bundle (RegDst, ALUOp, ALUSrc, Jump, J_Jump) that the ID/EX control register captures. It also handles load-use stalls, inserting one bubble and freezing PC and IF/ID. When EX resolves a taken branch or jump, it squashes the wrong-path instructions. It keeps saturating stall and flush counters for performance debug.

---
 rtl/id_issue_control.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_issue_control.sv
// ID-stage issue control: decodes the IF/ID word into the EX control bundle,
// inserts load-use bubbles, squashes wrong-path fetches after a redirect.
module id_issue_control #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  output logic             RegDst,
  output logic [3:0]       ALUOp,
  output logic             ALUSrc,
  output logic [1:0]       Jump,
  output logic             J_Jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [2:0] REM_LOAD = 3'(FLUSH_DEPTH - 1);

  logic [1:0] state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       stall_inc, flush_inc;

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       d_regdst, d_alusrc, d_jj, d_illegal, rt_src, hazard;
  logic [3:0] d_aluop;
  logic [1:0] d_jump;
  logic       unused_instr_bits;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];
  assign unused_instr_bits = ^instr[15:6];

  always_comb begin
    d_regdst  = 1'b0;
    d_aluop   = 4'b0000;
    d_alusrc  = 1'b0;
    d_jump    = 2'b00;
    d_jj      = 1'b0;
    d_illegal = 1'b0;
    rt_src    = 1'b0;
    case (op)
      6'h00: begin
        d_regdst = 1'b1;
        d_aluop  = 4'b0010;
        rt_src   = 1'b1;
        if (funct == 6'h08) d_jump = 2'b11;
      end
      6'h08:        begin d_aluop = 4'b0000; d_alusrc = 1'b1; end
      6'h0C:        begin d_aluop = 4'b0011; d_alusrc = 1'b1; end
      6'h0D:        begin d_aluop = 4'b0100; d_alusrc = 1'b1; end
      6'h0A:        begin d_aluop = 4'b0101; d_alusrc = 1'b1; end
      6'h23:        begin d_aluop = 4'b0000; d_alusrc = 1'b1; end
      6'h2B:        begin d_aluop = 4'b0000; d_alusrc = 1'b1; rt_src = 1'b1; end
      6'h04:        begin d_aluop = 4'b0001; d_jump = 2'b01; rt_src = 1'b1; end
      6'h05:        begin d_aluop = 4'b0001; d_jump = 2'b10; rt_src = 1'b1; end
      6'h02:        d_jj = 1'b1;
      default:      d_illegal = 1'b1;
    endcase
  end

  // lw does not read rt, so only real rt consumers are compared against ex_rt
  assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (rt_src && (ex_rt == rt)));

  always_comb begin
    RegDst     = 1'b0;
    ALUOp      = 4'b0000;
    ALUSrc     = 1'b0;
    Jump       = 2'b00;
    J_Jump     = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    illegal    = 1'b0;
    state_nxt  = state;
    rem_nxt    = rem;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (reset) begin
      state_nxt = S_RUN;
    end else if (ex_redirect) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_nxt  = (FLUSH_DEPTH > 1) ? S_FLUSH : S_RUN;
      rem_nxt    = (FLUSH_DEPTH > 1) ? REM_LOAD : 3'd0;
    end else begin
      case (state)
        S_RUN, S_STALL: begin
          illegal = d_illegal;
          if (state == S_RUN && hazard) begin
            stall_inc = 1'b1;
            state_nxt = S_STALL;
          end else begin
            RegDst     = d_regdst;
            ALUOp      = d_aluop;
            ALUSrc     = d_alusrc;
            Jump       = d_jump;
            J_Jump     = d_jj;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            state_nxt  = S_RUN;
          end
        end
        S_FLUSH: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          if (rem <= 3'd1) begin
            state_nxt = S_RUN;
            rem_nxt   = 3'd0;
          end else begin
            rem_nxt = rem - 3'd1;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      rem       <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
